// File: rtl/riscv_pkg.sv
// Shared CPU-side definitions: opcode constants and the data-memory responder state encoding.
package riscv_pkg;

  localparam logic [6:0]  LW    = 7'b0000011;
  localparam logic [6:0]  SW    = 7'b0100011;
  localparam logic [6:0]  ALUOP = 7'b0010011;
  localparam logic [31:0] NOP   = 32'h00000013;

  localparam int DMEM_MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Request fields held from accept until the array access.
  typedef struct packed {
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        fault;
  } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read.
// Latency: read data valid the cycle after en; no backpressure (always accepts).
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read returns the pre-write contents on a write cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait cycles, then response.
// Latency: accept at edge k -> rsp_valid from edge k+1+LATENCY. Backpressure: holds
// response until rsp_ready; req_ready only in IDLE. Optional alignment fault: DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT = 4'(LATENCY);

  dmem_state_t   state;
  logic [3:0]    count;
  dmem_req_t     cap;
  logic [AW-1:0] cap_idx;
  logic          pend;

  logic          accept;
  logic          req_fault;
  logic          range_fault;
  logic          acc_now;
  dmem_req_t     acc;
  logic [AW-1:0] acc_idx;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [31:0]   ram_rdata;

  assign req_ready   = (state == IDLE);
  assign accept      = req_ready && req_valid;
  assign range_fault = (req_addr[31:2] >= 30'(DEPTH_WORDS));

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_fault = range_fault | (req_addr[1:0] != 2'b00);
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^req_addr[1:0];
  assign req_fault      = range_fault;
`endif

  // With zero latency the array is accessed straight from the request inputs at accept.
  always_comb begin
    acc_now = 1'b0;
    acc     = cap;
    acc_idx = cap_idx;
    if (!rst) begin
      if (state == IDLE && accept && LAT == 4'd0) begin
        acc_now = 1'b1;
        acc     = '{we: req_we, wdata: req_wdata, be: req_be, fault: req_fault};
        acc_idx = req_addr[AW+1:2];
      end else if (state == WAIT && count == 4'd1) begin
        acc_now = 1'b1;
      end
    end
  end

  assign ram_en = acc_now && !acc.fault;
  assign ram_we = (acc.we && !acc.fault) ? acc.be : 4'b0000;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (acc_idx),
    .wdata(acc.wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 4'd0;
      cap       <= '0;
      cap_idx   <= '0;
      pend      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cap     <= '{we: req_we, wdata: req_wdata, be: req_be, fault: req_fault};
            cap_idx <= req_addr[AW+1:2];
            if (LAT == 4'd0) begin
              state <= RESP;
              pend  <= 1'b1;
            end else begin
              state <= WAIT;
              count <= LAT;
            end
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= RESP;
            pend  <= 1'b1;
          end
        end
        RESP: begin
          // First RESP cycle waits for the registered array read before presenting.
          if (pend) begin
            pend      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= cap.fault;
            rsp_rdata <= (cap.we || cap.fault) ? 32'd0 : ram_rdata;
          end else if (rsp_valid && rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (LATENCY=2, DEPTH_WORDS=1024); directed vectors.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   pop_cyc = 0;
  int   last_acc = 0;
  logic prev_v = 1'b0;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every consumed response.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid && !prev_v) rise_cyc = cyc;
    prev_v = rsp_valid;
    if (rsp_valid && rsp_ready && !rst) begin
      pop_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_latency", 32'(rise_cyc - e.acc), 32'd3);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata,
                       input logic exp_err, input logic push);
    bit ok;
    exp_t e;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("req_accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_acc  = cyc;
    req_valid = 1'b0;
    req_we    = 1'b1;
    req_addr  = 32'hFFFF_FFFC;
    req_wdata = 32'h5A5A_5A5A;
    req_be    = 4'hF;
    if (push) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.acc   = last_acc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    issue(we, addr, wdata, be, exp_rdata, exp_err, 1'b1);
    drain();
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_valid_timeout", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_state", {29'd0, rsp_valid, req_ready, rsp_err}, 32'b010);
      chk("idle_rdata", rsp_rdata, 32'd0);
    end
    @(posedge clk);
    #1;

    // Full-word round trip and a no-op store.
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    xact(1'b1, 32'h10, 32'h0000_0000, 4'h0, 32'd0, 1'b0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

    // Byte-masked merge.
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 32'd0, 1'b0);
    xact(1'b1, 32'h20, 32'h11223344, 4'h5, 32'd0, 1'b0);
    xact(1'b0, 32'h20, 32'h0, 4'h0, 32'hAA22CC44, 1'b0);

    // Backpressure with a second request waiting.
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1);
    wait_valid();
    req_we    = 1'b0;
    req_addr  = 32'h20;
    req_be    = 4'hF;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_ready", {30'd0, rsp_valid, req_ready}, 32'b10);
      chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 4'hF, 32'hAA22CC44, 1'b0, 1'b1);
    chk("accept_after_consume", 32'(last_acc - pop_cyc), 32'd2);
    drain();

    // Range faults and the last valid word.
    xact(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 32'd0, 1'b0);
    xact(1'b0, 32'h1000, 32'h0, 4'hF, 32'd0, 1'b1);
    xact(1'b1, 32'h1000, 32'h55555555, 4'hF, 32'd0, 1'b1);
    xact(1'b0, 32'h0, 32'h0, 4'hF, 32'h0BADF00D, 1'b0);
    xact(1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0);
    xact(1'b0, 32'hFFC, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);

    // Reset during WAIT abandons the store.
    xact(1'b1, 32'h30, 32'h12345678, 4'hF, 32'd0, 1'b0);
    issue(1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_state", {30'd0, rsp_valid, req_ready}, 32'b01);
    @(posedge clk);
    #1;
    xact(1'b0, 32'h30, 32'h0, 4'hF, 32'h12345678, 1'b0);

    // Reset during RESP discards the pending response.
    rsp_ready = 1'b0;
    issue(1'b0, 32'h30, 32'h0, 4'hF, 32'd0, 1'b0, 1'b0);
    wait_valid();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_state", {29'd0, rsp_valid, req_ready, rsp_err}, 32'b010);
    chk("rst_resp_rdata", rsp_rdata, 32'd0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;

`ifdef DMEM_ALIGN_CHECK_EN
    xact(1'b0, 32'h32, 32'h0, 4'hF, 32'd0, 1'b1);
    xact(1'b1, 32'h31, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1);
    xact(1'b0, 32'h30, 32'h0, 4'hF, 32'h12345678, 1'b0);
`else
    xact(1'b0, 32'h32, 32'h0, 4'hF, 32'h12345678, 1'b0);
`endif

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
